// File: rtl/intersection_phase_scheduler.sv
// Purpose : two-approach (N/S, E/W) traffic-light phase sequencer with request-driven early green cut.
// Latency : phase changes only on the prescaler tick; a button rise becomes pend_* on the 3rd clk edge.
// Backpressure: none; buttons are sampled levels, lights are a pure decode of the phase register.
//
// Ports:
//   clk              clock
//   reset            synchronous, active-high reset
//   req_ns, req_ew   asynchronous push-buttons requesting N/S or E/W green
//   light_ns/_ew     RGB codes: red 100, yellow 110, green 010
//   phase            current phase code (0 NS_GREEN .. 5 RED_B)
//   pend_ns/_ew      latched request not yet served
//   tick             one-cycle prescaler pulse that paces every phase transition
module intersection_phase_scheduler #(
    parameter int TICK_DIV  = 100_000_000,
    parameter int GREEN_MAX = 10,
    parameter int GREEN_MIN = 4,
    parameter int YELLOW    = 3,
    parameter int ALL_RED   = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_ns,
    input  logic       req_ew,
    output logic [2:0] light_ns,
    output logic [2:0] light_ew,
    output logic [2:0] phase,
    output logic       pend_ns,
    output logic       pend_ew,
    output logic       tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int TMAX  = (GREEN_MAX > YELLOW)
                         ? ((GREEN_MAX > ALL_RED) ? GREEN_MAX : ALL_RED)
                         : ((YELLOW > ALL_RED) ? YELLOW : ALL_RED);
    localparam int ELA_W = $clog2(TMAX + 1);

    localparam logic [2:0] NS_GREEN  = 3'd0;
    localparam logic [2:0] NS_YELLOW = 3'd1;
    localparam logic [2:0] RED_A     = 3'd2;
    localparam logic [2:0] EW_GREEN  = 3'd3;
    localparam logic [2:0] EW_YELLOW = 3'd4;
    localparam logic [2:0] RED_B     = 3'd5;

    localparam logic [2:0] LT_RED    = 3'b100;
    localparam logic [2:0] LT_YELLOW = 3'b110;
    localparam logic [2:0] LT_GREEN  = 3'b010;

    // ------------------------------------------------------------------
    // Prescaler
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] pre_q, pre_d;
    logic             tick_w;

    assign tick_w = (pre_q == CNT_W'(TICK_DIV - 1));
    assign pre_d  = tick_w ? '0 : pre_q + CNT_W'(1);

    // ------------------------------------------------------------------
    // Button synchronizers and rising-edge detect. The third flop holds the
    // previous synchronized level so a held button yields one edge only.
    // ------------------------------------------------------------------
    logic ns_s1_q, ns_s2_q, ns_s3_q;
    logic ew_s1_q, ew_s2_q, ew_s3_q;
    logic rise_ns, rise_ew;

    assign rise_ns = ns_s2_q & ~ns_s3_q;
    assign rise_ew = ew_s2_q & ~ew_s3_q;

    // ------------------------------------------------------------------
    // Phase FSM
    // ------------------------------------------------------------------
    logic [2:0]       phase_q, phase_d;
    logic [ELA_W-1:0] elapsed_q, elapsed_d;
    logic [ELA_W-1:0] e;
    logic             done;
    logic [2:0]       phase_next;
    logic             pend_ns_q, pend_ns_d;
    logic             pend_ew_q, pend_ew_d;

    // e is the tick count the phase will have reached once the current tick lands.
    assign e = elapsed_q + ELA_W'(1);

    always_comb begin
        done       = 1'b0;
        phase_next = NS_GREEN;
        case (phase_q)
            NS_GREEN: begin
                done       = (e == ELA_W'(GREEN_MAX)) ||
                             (pend_ew_q && (e >= ELA_W'(GREEN_MIN)));
                phase_next = NS_YELLOW;
            end
            NS_YELLOW: begin
                done       = (e == ELA_W'(YELLOW));
                phase_next = RED_A;
            end
            RED_A: begin
                done       = (e == ELA_W'(ALL_RED));
                phase_next = EW_GREEN;
            end
            EW_GREEN: begin
                done       = (e == ELA_W'(GREEN_MAX)) ||
                             (pend_ns_q && (e >= ELA_W'(GREEN_MIN)));
                phase_next = EW_YELLOW;
            end
            EW_YELLOW: begin
                done       = (e == ELA_W'(YELLOW));
                phase_next = RED_B;
            end
            RED_B: begin
                done       = (e == ELA_W'(ALL_RED));
                phase_next = NS_GREEN;
            end
            default: begin
                done       = 1'b0;
                phase_next = NS_GREEN;
            end
        endcase
    end

    always_comb begin
        phase_d   = phase_q;
        elapsed_d = elapsed_q;
        if (phase_q > RED_B) begin
            // Illegal codes recover immediately, without waiting for a tick.
            phase_d   = NS_GREEN;
            elapsed_d = '0;
        end else if (tick_w) begin
            if (done) begin
                phase_d   = phase_next;
                elapsed_d = '0;
            end else begin
                elapsed_d = e;
            end
        end
    end

    // A new edge outranks the clear on green entry so a request arriving on
    // that very edge is not lost. Edges during the approach's own green are
    // already being served and are dropped.
    always_comb begin
        pend_ns_d = pend_ns_q;
        if (rise_ns && (phase_q != NS_GREEN)) begin
            pend_ns_d = 1'b1;
        end else if ((phase_d == NS_GREEN) && (phase_q != NS_GREEN)) begin
            pend_ns_d = 1'b0;
        end
    end

    always_comb begin
        pend_ew_d = pend_ew_q;
        if (rise_ew && (phase_q != EW_GREEN)) begin
            pend_ew_d = 1'b1;
        end else if ((phase_d == EW_GREEN) && (phase_q != EW_GREEN)) begin
            pend_ew_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pre_q     <= '0;
            phase_q   <= NS_GREEN;
            elapsed_q <= '0;
            pend_ns_q <= 1'b0;
            pend_ew_q <= 1'b0;
            ns_s1_q   <= 1'b0;
            ns_s2_q   <= 1'b0;
            ns_s3_q   <= 1'b0;
            ew_s1_q   <= 1'b0;
            ew_s2_q   <= 1'b0;
            ew_s3_q   <= 1'b0;
        end else begin
            pre_q     <= pre_d;
            phase_q   <= phase_d;
            elapsed_q <= elapsed_d;
            pend_ns_q <= pend_ns_d;
            pend_ew_q <= pend_ew_d;
            ns_s1_q   <= req_ns;
            ns_s2_q   <= ns_s1_q;
            ns_s3_q   <= ns_s2_q;
            ew_s1_q   <= req_ew;
            ew_s2_q   <= ew_s1_q;
            ew_s3_q   <= ew_s2_q;
        end
    end

    // ------------------------------------------------------------------
    // Light decode
    // ------------------------------------------------------------------
    always_comb begin
        light_ns = LT_RED;
        light_ew = LT_RED;
        case (phase_q)
            NS_GREEN:  light_ns = LT_GREEN;
            NS_YELLOW: light_ns = LT_YELLOW;
            EW_GREEN:  light_ew = LT_GREEN;
            EW_YELLOW: light_ew = LT_YELLOW;
            default: begin
                light_ns = LT_RED;
                light_ew = LT_RED;
            end
        endcase
    end

    assign phase   = phase_q;
    assign pend_ns = pend_ns_q;
    assign pend_ew = pend_ew_q;
    assign tick    = tick_w;

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Purpose : self-checking bench for intersection_phase_scheduler (TICK_DIV=4).
// Latency : inputs driven on negedge, outputs sampled on negedge.
// Backpressure: not applicable.
module tb_intersection_phase_scheduler;

    localparam int TD   = 4;
    localparam int GMAX = 10;
    localparam int GMIN = 4;
    localparam int YEL  = 3;
    localparam int AR   = 1;

    logic       clk    = 1'b0;
    logic       reset  = 1'b1;
    logic       req_ns = 1'b0;
    logic       req_ew = 1'b0;
    logic [2:0] light_ns, light_ew, phase;
    logic       pend_ns, pend_ew, tick;

    int tests = 0;
    int fails = 0;

    intersection_phase_scheduler #(
        .TICK_DIV (TD),
        .GREEN_MAX(GMAX),
        .GREEN_MIN(GMIN),
        .YELLOW   (YEL),
        .ALL_RED  (AR)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .req_ns  (req_ns),
        .req_ew  (req_ew),
        .light_ns(light_ns),
        .light_ew(light_ew),
        .phase   (phase),
        .pend_ns (pend_ns),
        .pend_ew (pend_ew),
        .tick    (tick)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Reference model: phase index, tick count within the phase, second
    // counter and a short history of sampled button levels.
    // ------------------------------------------------------------------
    int       m_cnt = 0;
    int       m_ph  = 0;
    int       m_el  = 0;
    bit       m_pns = 1'b0;
    bit       m_pew = 1'b0;
    bit [2:0] hns   = 3'b0;
    bit [2:0] hew   = 3'b0;

    function automatic int ph_len(input int p);
        if (p == 0 || p == 3) return GMAX;
        if (p == 1 || p == 4) return YEL;
        return AR;
    endfunction

    function automatic logic [2:0] lt_ns(input int p);
        if (p == 0) return 3'b010;
        if (p == 1) return 3'b110;
        return 3'b100;
    endfunction

    function automatic logic [2:0] lt_ew(input int p);
        if (p == 3) return 3'b010;
        if (p == 4) return 3'b110;
        return 3'b100;
    endfunction

    always @(posedge clk) begin
        int  e, nph, nel;
        bit  fin, tk, rns, rew;
        if (reset) begin
            m_cnt = 0; m_ph = 0; m_el = 0;
            m_pns = 1'b0; m_pew = 1'b0;
            hns = 3'b0; hew = 3'b0;
        end else begin
            tk  = (m_cnt == TD - 1);
            rns = hns[1] & ~hns[2];
            rew = hew[1] & ~hew[2];
            nph = m_ph;
            nel = m_el;
            if (tk) begin
                e = m_el + 1;
                if (m_ph == 0)      fin = (e == GMAX) || (m_pew && e >= GMIN);
                else if (m_ph == 3) fin = (e == GMAX) || (m_pns && e >= GMIN);
                else                fin = (e == ph_len(m_ph));
                if (fin) begin
                    nph = (m_ph + 1) % 6;
                    nel = 0;
                end else begin
                    nel = e;
                end
            end
            if (rns && m_ph != 0)            m_pns = 1'b1;
            else if (nph == 0 && m_ph != 0)  m_pns = 1'b0;
            if (rew && m_ph != 3)            m_pew = 1'b1;
            else if (nph == 3 && m_ph != 3)  m_pew = 1'b0;
            m_ph  = nph;
            m_el  = nel;
            hns   = {hns[1:0], req_ns};
            hew   = {hew[1:0], req_ew};
            m_cnt = (m_cnt + 1) % TD;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (no checking inside)
    // ------------------------------------------------------------------
    // Ends on the negedge of the first cycle after reset release.
    task automatic do_reset();
        @(negedge clk);
        reset  = 1'b1;
        req_ns = 1'b0;
        req_ew = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_phase(input int p, input int budget, output int n);
        n = 0;
        while (phase !== 3'(p) && n < budget) begin
            @(negedge clk);
            n++;
        end
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        int k;
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        tests++;
        if (phase !== 3'd0 || light_ns !== 3'b010 || light_ew !== 3'b100 ||
            pend_ns !== 1'b0 || pend_ew !== 1'b0 || tick !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: phase=%0d lns=%b lew=%b pns=%b pew=%b tick=%b, want 0 010 100 0 0 0",
                     phase, light_ns, light_ew, pend_ns, pend_ew, tick);
        end
        reset = 1'b0;
        k = 1;
        while (tick !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        tests++;
        if (k != TD) begin
            fails++;
            $display("FAIL reset_first_tick: tick in cycle %0d, want %0d", k, TD);
        end
    endtask

    task automatic test_free_run();
        int n, total;
        do_reset();
        total = 0;
        for (int i = 0; i < 6; i++) begin
            tests++;
            if (phase !== 3'(i) || light_ns !== lt_ns(i) || light_ew !== lt_ew(i)) begin
                fails++;
                $display("FAIL free_lights_%0d: phase=%0d lns=%b lew=%b, want %0d %b %b",
                         i, phase, light_ns, light_ew, i, lt_ns(i), lt_ew(i));
            end
            n = 0;
            while (phase === 3'(i) && n < 200) begin
                @(negedge clk);
                n++;
            end
            total += n;
            tests++;
            if (n != ph_len(i) * TD) begin
                fails++;
                $display("FAIL free_len_%0d: %0d clk, want %0d", i, n, ph_len(i) * TD);
            end
        end
        tests++;
        if (total != 2 * (GMAX + YEL + AR) * TD || phase !== 3'd0) begin
            fails++;
            $display("FAIL free_period: %0d clk ending in phase %0d, want %0d ending in 0",
                     total, phase, 2 * (GMAX + YEL + AR) * TD);
        end
    endtask

    // Pulses req_ew after `wait_ticks` ticks of NS_GREEN and checks the cut point.
    task automatic run_ew_cut(input int wait_ticks, input int want_ticks, input string tag);
        int k, n;
        do_reset();
        repeat (wait_ticks * TD) @(negedge clk);
        req_ew = 1'b1;
        @(negedge clk);
        req_ew = 1'b0;
        k = 1;
        while (pend_ew !== 1'b1 && k < 3) begin
            @(negedge clk);
            k++;
        end
        tests++;
        if (pend_ew !== 1'b1) begin
            fails++;
            $display("FAIL %s_pend_set: pend_ew=%b after %0d clk, want 1", tag, pend_ew, k);
        end
        wait_phase(1, 200, n);
        tests++;
        if (phase !== 3'd1 || wait_ticks * TD + k + n != want_ticks * TD) begin
            fails++;
            $display("FAIL %s_green_len: phase=%0d green %0d clk, want phase 1 after %0d clk",
                     tag, phase, wait_ticks * TD + k + n, want_ticks * TD);
        end
        wait_phase(2, 200, n);
        tests++;
        if (phase !== 3'd2 || pend_ew !== 1'b1) begin
            fails++;
            $display("FAIL %s_pend_hold: phase=%0d pend_ew=%b, want 2 1", tag, phase, pend_ew);
        end
        wait_phase(3, 200, n);
        tests++;
        if (phase !== 3'd3 || pend_ew !== 1'b0) begin
            fails++;
            $display("FAIL %s_pend_clear: phase=%0d pend_ew=%b, want 3 0", tag, phase, pend_ew);
        end
    endtask

    task automatic test_early_cut();
        run_ew_cut(1, GMIN, "early");
    endtask

    task automatic test_late_cut();
        run_ew_cut(7, 8, "late");
    endtask

    task automatic test_held_ns();
        int n, bad;
        do_reset();
        req_ns = 1'b1;
        n = 0;
        bad = 0;
        while (phase === 3'd0 && n < 200) begin
            if (pend_ns !== 1'b0) bad++;
            @(negedge clk);
            n++;
        end
        tests++;
        if (bad != 0 || n != GMAX * TD) begin
            fails++;
            $display("FAIL held_ns: pend_ns high %0d cycles, green %0d clk, want 0 and %0d",
                     bad, n, GMAX * TD);
        end
        wait_phase(0, 300, n);
        tests++;
        if (phase !== 3'd0 || pend_ns !== 1'b0) begin
            fails++;
            $display("FAIL held_ns_cycle: phase=%0d pend_ns=%b, want 0 0", phase, pend_ns);
        end
        req_ns = 1'b0;
    endtask

    task automatic test_both_ew_yellow();
        int n;
        do_reset();
        wait_phase(4, 200, n);
        req_ns = 1'b1;
        req_ew = 1'b1;
        @(negedge clk);
        req_ns = 1'b0;
        req_ew = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if (phase !== 3'd4 || pend_ns !== 1'b1 || pend_ew !== 1'b1) begin
            fails++;
            $display("FAIL both_set: phase=%0d pns=%b pew=%b, want 4 1 1", phase, pend_ns, pend_ew);
        end
        wait_phase(0, 200, n);
        tests++;
        if (phase !== 3'd0 || pend_ns !== 1'b0 || pend_ew !== 1'b1) begin
            fails++;
            $display("FAIL both_ns_entry: phase=%0d pns=%b pew=%b, want 0 0 1", phase, pend_ns, pend_ew);
        end
        n = 0;
        while (phase === 3'd0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (n != GMIN * TD) begin
            fails++;
            $display("FAIL both_ns_green_len: %0d clk, want %0d", n, GMIN * TD);
        end
        wait_phase(3, 200, n);
        tests++;
        if (phase !== 3'd3 || pend_ew !== 1'b0) begin
            fails++;
            $display("FAIL both_ew_entry: phase=%0d pew=%b, want 3 0", phase, pend_ew);
        end
    endtask

    task automatic test_reset_mid();
        int n, k;
        do_reset();
        wait_phase(3, 200, n);
        repeat (5) @(negedge clk);
        req_ns = 1'b1;
        @(negedge clk);
        req_ns = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if (phase !== 3'd3 || pend_ns !== 1'b1) begin
            fails++;
            $display("FAIL mid_pre: phase=%0d pns=%b, want 3 1", phase, pend_ns);
        end
        reset = 1'b1;
        @(negedge clk);
        tests++;
        if (phase !== 3'd0 || light_ns !== 3'b010 || light_ew !== 3'b100 ||
            pend_ns !== 1'b0 || pend_ew !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset: phase=%0d lns=%b lew=%b pns=%b pew=%b, want 0 010 100 0 0",
                     phase, light_ns, light_ew, pend_ns, pend_ew);
        end
        reset = 1'b0;
        k = 1;
        while (tick !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        tests++;
        if (k != TD || phase !== 3'd0) begin
            fails++;
            $display("FAIL mid_first_tick: tick in cycle %0d phase=%0d, want %0d and 0", k, phase, TD);
        end
    endtask

    task automatic test_random();
        int local_fails;
        do_reset();
        local_fails = 0;
        for (int i = 0; i < 4000 && local_fails < 8; i++) begin
            tests++;
            if (phase !== 3'(m_ph) || light_ns !== lt_ns(m_ph) || light_ew !== lt_ew(m_ph) ||
                pend_ns !== m_pns || pend_ew !== m_pew || tick !== (m_cnt == TD - 1)) begin
                fails++;
                local_fails++;
                $display("FAIL random_cycle_%0d: got ph=%0d lns=%b lew=%b pns=%b pew=%b tick=%b, want ph=%0d lns=%b lew=%b pns=%b pew=%b tick=%b",
                         i, phase, light_ns, light_ew, pend_ns, pend_ew, tick,
                         m_ph, lt_ns(m_ph), lt_ew(m_ph), m_pns, m_pew, (m_cnt == TD - 1));
            end
            if ($urandom_range(0, 19) == 0) req_ns = ~req_ns;
            if ($urandom_range(0, 19) == 0) req_ew = ~req_ew;
            reset = ($urandom_range(0, 799) == 0);
            @(negedge clk);
        end
        reset  = 1'b0;
        req_ns = 1'b0;
        req_ew = 1'b0;
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_early_cut();
        test_late_cut();
        test_held_ns();
        test_both_ew_yellow();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
